// File: rtl/src_p_bank_arbiter_pkg.sv
// Shared types and sizing for the vertex-bank read arbiter.
// Each bank's delay-line entry records which pipe to return data to and which tag to send with it.
package src_p_bank_arbiter_pkg;
    localparam int PIPE_NUM     = 4;
    localparam int BANK_NUM     = 4;
    localparam int BANK_WIDTH   = 2;
    localparam int PIPE_WIDTH   = 2;
    localparam int SRC_P_AWIDTH = 10;
    localparam int SRC_P_DWIDTH = 32;
    localparam int LOC_X_WIDTH  = 3;
    localparam int LOC_Y_WIDTH  = 3;
    localparam int TAG_WIDTH    = LOC_X_WIDTH + LOC_Y_WIDTH;
    localparam int RD_LATENCY   = 2;

    typedef struct packed {
        logic [LOC_X_WIDTH-1:0] loc_x;
        logic [LOC_Y_WIDTH-1:0] loc_y;
    } tag_t;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_WIDTH-1:0] pipe_id;
        tag_t                  tag;
    } dl_entry_t;

    function automatic logic [PIPE_WIDTH-1:0] onehot_to_idx(input logic [PIPE_NUM-1:0] oh);
        logic [PIPE_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < PIPE_NUM; i++)
            if (oh[i]) idx = PIPE_WIDTH'(i);
        return idx;
    endfunction
endpackage

// File: rtl/src_p_bank_arbiter_if.sv
// Request, BRAM and response bundle between the edge pipes, the arbiter and the vertex banks.
interface src_p_bank_arbiter_if;
    import src_p_bank_arbiter_pkg::*;

    logic [PIPE_NUM-1:0]              req_valid;
    logic [PIPE_NUM*SRC_P_AWIDTH-1:0] req_addr;
    logic [PIPE_NUM*BANK_WIDTH-1:0]   req_bank;
    logic [PIPE_NUM*TAG_WIDTH-1:0]    req_tag;
    logic [PIPE_NUM-1:0]              req_ready;
    logic                             back_stage_full;
    logic [BANK_NUM-1:0]              bank_rd_en;
    logic [BANK_NUM*SRC_P_AWIDTH-1:0] bank_rd_addr;
    logic [BANK_NUM*SRC_P_DWIDTH-1:0] bank_rd_data;
    logic [PIPE_NUM-1:0]              rsp_valid;
    logic [PIPE_NUM*SRC_P_DWIDTH-1:0] rsp_data;
    logic [PIPE_NUM*TAG_WIDTH-1:0]    rsp_tag;

    modport master (
        output req_valid, req_addr, req_bank, req_tag, back_stage_full, bank_rd_data,
        input  req_ready, bank_rd_en, bank_rd_addr, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_addr, req_bank, req_tag, back_stage_full, bank_rd_data,
        output req_ready, bank_rd_en, bank_rd_addr, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/src_p_bank_arbiter_rr.sv
// Four-way round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the grantee only when the grant is actually taken.
module rr_arbiter_4 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic       i_adv,
    output logic [3:0] o_gnt
);
    logic [1:0] r_ptr;
    logic [1:0] w_sel;
    logic       w_hit;

    // Scan from the far end so the nearest requester after the pointer wins.
    always_comb begin
        o_gnt = '0;
        w_sel = r_ptr;
        w_hit = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (i_req[r_ptr + 2'(k)]) begin
                w_hit = 1'b1;
                w_sel = r_ptr + 2'(k);
            end
        end
        if (w_hit) o_gnt[w_sel] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)            r_ptr <= '0;
        else if (i_adv && w_hit) r_ptr <= w_sel + 2'd1;
    end
endmodule

// File: rtl/src_p_bank_arbiter.sv
// Shares the vertex BRAM banks among the edge pipes: per-bank round-robin grant,
// registered issue, and a per-bank delay line that steers read data back to its pipe.
module src_p_bank_arbiter
    import src_p_bank_arbiter_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    src_p_bank_arbiter_if.slave    io_if
);
    logic [BANK_NUM-1:0][PIPE_NUM-1:0]     w_req;
    logic [BANK_NUM-1:0][PIPE_NUM-1:0]     w_gnt;
    logic [BANK_NUM-1:0]                   w_take;
    logic [BANK_NUM-1:0][PIPE_WIDTH-1:0]   w_gid;
    logic [PIPE_NUM-1:0]                   w_ready;
    logic [PIPE_NUM-1:0][SRC_P_AWIDTH-1:0] w_addr;
    tag_t [PIPE_NUM-1:0]                   w_tag;
    logic [BANK_NUM-1:0][SRC_P_DWIDTH-1:0] w_rd_data;

    logic [BANK_NUM-1:0]                   r_rd_en;
    logic [BANK_NUM-1:0][SRC_P_AWIDTH-1:0] r_rd_addr;
    dl_entry_t                             r_dl [BANK_NUM][RD_LATENCY+1];
    logic [PIPE_NUM-1:0]                   r_rsp_valid;
    logic [PIPE_NUM-1:0][SRC_P_DWIDTH-1:0] r_rsp_data;
    tag_t [PIPE_NUM-1:0]                   r_rsp_tag;

    assign w_addr    = io_if.req_addr;
    assign w_tag     = io_if.req_tag;
    assign w_rd_data = io_if.bank_rd_data;

    always_comb begin
        w_req   = '0;
        w_take  = '0;
        w_gid   = '0;
        w_ready = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            for (int i = 0; i < PIPE_NUM; i++)
                w_req[b][i] = io_if.req_valid[i] &&
                              (io_if.req_bank[i*BANK_WIDTH +: BANK_WIDTH] == BANK_WIDTH'(b));
            w_take[b] = (|w_gnt[b]) && !io_if.back_stage_full;
            w_gid[b]  = onehot_to_idx(w_gnt[b]);
            w_ready   = w_ready | w_gnt[b];
        end
    end

    // A pipe targets one bank, so OR-ing the bank grants never yields two grants per pipe.
    assign io_if.req_ready = (i_rst && !io_if.back_stage_full) ? w_ready : '0;

    genvar b;
    generate
        for (b = 0; b < BANK_NUM; b++) begin : g_bank
            rr_arbiter_4 u_rr (
                .i_clk   (i_clk),
                .i_rst_n (i_rst),
                .i_req   (w_req[b]),
                .i_adv   (w_take[b]),
                .o_gnt   (w_gnt[b])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_en     <= '0;
            r_rd_addr   <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
            for (int k = 0; k < BANK_NUM; k++)
                for (int s = 0; s <= RD_LATENCY; s++)
                    r_dl[k][s] <= '0;
        end else begin
            for (int k = 0; k < BANK_NUM; k++) begin
                r_rd_en[k]   <= w_take[k];
                r_rd_addr[k] <= w_take[k] ? w_addr[w_gid[k]] : '0;
                r_dl[k][0]   <= '{valid: w_take[k], pipe_id: w_gid[k], tag: w_tag[w_gid[k]]};
                for (int s = 1; s <= RD_LATENCY; s++)
                    r_dl[k][s] <= r_dl[k][s-1];
            end
            // Last stage lines up with bank_rd_data; at most one bank returns to a given pipe.
            r_rsp_valid <= '0;
            for (int k = 0; k < BANK_NUM; k++) begin
                if (r_dl[k][RD_LATENCY].valid) begin
                    r_rsp_valid[r_dl[k][RD_LATENCY].pipe_id] <= 1'b1;
                    r_rsp_data[r_dl[k][RD_LATENCY].pipe_id]  <= w_rd_data[k];
                    r_rsp_tag[r_dl[k][RD_LATENCY].pipe_id]   <= r_dl[k][RD_LATENCY].tag;
                end
            end
        end
    end

    assign io_if.bank_rd_en   = r_rd_en;
    assign io_if.bank_rd_addr = r_rd_addr;
    assign io_if.rsp_valid    = r_rsp_valid;
    assign io_if.rsp_data     = r_rsp_data;
    assign io_if.rsp_tag      = r_rsp_tag;
endmodule

// File: tb/tb_src_p_bank_arbiter.sv
// Bench for src_p_bank_arbiter: directed vector table, hand-written reset sequences and
// random traffic, all checked against a cycle-indexed reference model with a BRAM stand-in.
module tb_src_p_bank_arbiter;
    import src_p_bank_arbiter_pkg::*;

    localparam int AW = SRC_P_AWIDTH;
    localparam int DW = SRC_P_DWIDTH;
    localparam int TW = TAG_WIDTH;
    localparam int N  = 1024;

    logic clk;
    logic rst;
    src_p_bank_arbiter_if bus();

    src_p_bank_arbiter dut (.i_clk(clk), .i_rst(rst), .io_if(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem(input int b, input logic [AW-1:0] a);
        return 32'hB000_0000 ^ (32'(b) << 20) ^ (32'(a) * 32'h0001_0003) ^ 32'h0000_05A5;
    endfunction

    // BRAM stand-in: data appears RD_LATENCY cycles after the address is presented.
    logic [DW-1:0] bram_q [BANK_NUM][RD_LATENCY];
    always @(posedge clk) begin
        for (int k = 0; k < BANK_NUM; k++) begin
            bram_q[k][0] <= mem(k, bus.bank_rd_addr[k*AW +: AW]);
            for (int s = 1; s < RD_LATENCY; s++) bram_q[k][s] <= bram_q[k][s-1];
        end
    end
    always_comb begin
        bus.bank_rd_data = '0;
        for (int k = 0; k < BANK_NUM; k++) bus.bank_rd_data[k*DW +: DW] = bram_q[k][RD_LATENCY-1];
    end

    // Reference model state, expectations indexed by cycle number.
    int n_chk, n_err, cyc;
    int ptr [BANK_NUM];
    bit [3:0]          exp_en   [N];
    bit [3:0][AW-1:0]  exp_addr [N];
    bit [3:0]          exp_rv   [N];
    bit [3:0][DW-1:0]  exp_rd   [N];
    bit [3:0][TW-1:0]  exp_rt   [N];

    logic [3:0]         v_valid;
    logic [3:0][AW-1:0] v_addr;
    logic [3:0][1:0]    v_bank;
    logic [3:0][TW-1:0] v_tag;
    logic               v_full, v_rst;

    typedef struct packed {
        logic [3:0]         valid;
        logic [3:0][1:0]    bank;
        logic [3:0][AW-1:0] addr;
        logic [3:0][TW-1:0] tag;
        logic               full;
        logic [3:0]         exp_ready;
        logic [3:0]         exp_en;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic step(output logic [3:0] got_ready, output logic [3:0] got_en);
        logic [3:0] er;
        bit         found;
        int         g, idx, r;
        bus.req_valid       = v_valid;
        bus.req_addr        = v_addr;
        bus.req_bank        = v_bank;
        bus.req_tag         = v_tag;
        bus.back_stage_full = v_full;
        rst                 = v_rst;
        #1;
        er = '0;
        if (!v_rst) begin
            for (int k = 0; k < BANK_NUM; k++) ptr[k] = 0;
            for (int c = cyc + 1; c < cyc + 9; c++) begin
                exp_en[c] = '0; exp_addr[c] = '0; exp_rv[c] = '0;
            end
            chk("reset_outs", {bus.req_ready, bus.bank_rd_en, bus.rsp_valid,
                |bus.bank_rd_addr, |bus.rsp_data, |bus.rsp_tag}, '0);
        end else begin
            for (int k = 0; k < BANK_NUM; k++) begin
                found = 1'b0; g = 0;
                for (int o = 0; o < PIPE_NUM; o++) begin
                    idx = (ptr[k] + o) % PIPE_NUM;
                    if (!found && v_valid[idx] && int'(v_bank[idx]) == k) begin
                        found = 1'b1; g = idx;
                    end
                end
                if (found && !v_full) begin
                    er[g]             = 1'b1;
                    ptr[k]            = (g + 1) % PIPE_NUM;
                    exp_en[cyc+1][k]  = 1'b1;
                    exp_addr[cyc+1][k] = v_addr[g];
                    r                 = cyc + RD_LATENCY + 2;
                    exp_rv[r][g]      = 1'b1;
                    exp_rd[r][g]      = mem(k, v_addr[g]);
                    exp_rt[r][g]      = v_tag[g];
                end
            end
            chk("req_ready", bus.req_ready, er);
        end
        got_ready = bus.req_ready;
        @(posedge clk);
        cyc++;
        #1;
        chk("bank_rd_en", bus.bank_rd_en, exp_en[cyc]);
        chk("bank_rd_addr", bus.bank_rd_addr, exp_addr[cyc]);
        chk("rsp_valid", bus.rsp_valid, exp_rv[cyc]);
        for (int p = 0; p < PIPE_NUM; p++) begin
            if (exp_rv[cyc][p]) begin
                chk("rsp_data", bus.rsp_data[p*DW +: DW], exp_rd[cyc][p]);
                chk("rsp_tag", bus.rsp_tag[p*TW +: TW], exp_rt[cyc][p]);
            end
        end
        got_en = bus.bank_rd_en;
        @(negedge clk);
    endtask

    task automatic randomize_req();
        v_valid = 4'($urandom);
        for (int i = 0; i < PIPE_NUM; i++) begin
            v_bank[i] = 2'($urandom_range(0, 3));
            v_addr[i] = AW'($urandom);
            v_tag[i]  = TW'($urandom);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] va, input logic [7:0] bk, input logic [39:0] ad,
                                input logic [23:0] tg, input logic fu, input logic [3:0] er,
                                input logic [3:0] ee);
        vec_t t;
        t.valid = va; t.bank = bk; t.addr = ad; t.tag = tg;
        t.full = fu; t.exp_ready = er; t.exp_en = ee;
        return t;
    endfunction

    logic [3:0] gr, ge;
    logic [3:0] seen_rv;

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        for (int k = 0; k < BANK_NUM; k++) ptr[k] = 0;
        rst = 1'b0;
        v_rst = 1'b0; v_full = 1'b0;
        randomize_req();

        // Contention on bank 2, conflict-free, back-pressure, tag routing, then drain.
        for (int i = 0; i < 5; i++) tbl[i] = mk(4'hF, 8'hAA, {10'h23, 10'h22, 10'h21, 10'h20},
                                               {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 4'b0001 << (i % 4), 4'b0100);
        tbl[5] = mk(4'hF, 8'b11_10_01_00, {10'h13, 10'h12, 10'h11, 10'h10},
                    {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 4'b1111, 4'b1111);
        for (int i = 6; i < 9; i++) tbl[i] = mk(4'hF, 8'hAA, {10'h23, 10'h22, 10'h21, 10'h20},
                                               {6'd4, 6'd3, 6'd2, 6'd1}, 1'b1, 4'b0000, 4'b0000);
        tbl[9]  = mk(4'hF, 8'hAA, {10'h23, 10'h22, 10'h21, 10'h20},
                     {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 4'b1000, 4'b0100);
        tbl[10] = mk(4'hF, 8'hAA, {10'h23, 10'h22, 10'h21, 10'h20},
                     {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 4'b0001, 4'b0100);
        tbl[11] = mk(4'b1010, 8'b01_00_00_00, {10'h33, 10'h0, 10'h31, 10'h0},
                     {6'h2A, 6'h0, 6'h15, 6'h0}, 1'b0, 4'b1010, 4'b0011);
        for (int i = 12; i < 18; i++) tbl[i] = mk(4'h0, 8'h00, '0, '0, 1'b0, 4'b0000, 4'b0000);

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            randomize_req();
            step(gr, ge);
        end

        v_rst = 1'b1;
        for (int i = 0; i < 18; i++) begin
            v_valid = tbl[i].valid; v_bank = tbl[i].bank; v_addr = tbl[i].addr;
            v_tag = tbl[i].tag; v_full = tbl[i].full;
            step(gr, ge);
            chk("tbl_ready", gr, tbl[i].exp_ready);
            chk("tbl_en", ge, tbl[i].exp_en);
            if (i == 14) begin
                chk("route_valid", {bus.rsp_valid[3], bus.rsp_valid[1]}, 2'b11);
                chk("route_tag3", bus.rsp_tag[3*TW +: TW], 6'h2A);
                chk("route_tag1", bus.rsp_tag[1*TW +: TW], 6'h15);
                chk("route_data3", bus.rsp_data[3*DW +: DW], mem(1, 10'h33));
                chk("route_data1", bus.rsp_data[1*DW +: DW], mem(0, 10'h31));
            end
        end

        for (int i = 0; i < 300; i++) begin
            randomize_req();
            v_full = ($urandom_range(0, 4) == 0);
            step(gr, ge);
        end

        // Reset one cycle after a burst of grants: in-flight reads must vanish.
        v_full = 1'b0;
        v_valid = 4'hF; v_bank = 8'b11_10_01_00;
        v_addr = {10'h13, 10'h12, 10'h11, 10'h10}; v_tag = {6'd4, 6'd3, 6'd2, 6'd1};
        step(gr, ge);
        v_valid = 4'h0;
        step(gr, ge);
        v_rst = 1'b0;
        step(gr, ge);
        v_rst = 1'b1;
        seen_rv = '0;
        for (int i = 0; i < 6; i++) begin
            step(gr, ge);
            seen_rv = seen_rv | bus.rsp_valid;
        end
        chk("no_rsp_after_reset", seen_rv, 4'b0000);
        v_valid = 4'hF; v_bank = 8'hAA;
        step(gr, ge);
        chk("ptr_reset_first_grant", gr, 4'b0001);
        v_valid = 4'h0;
        for (int i = 0; i < 6; i++) step(gr, ge);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
